// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and alu_arbiter.
// The master side is the requester pair; the slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int N = 64
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [3:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [3:0]   req1_op;

    logic         rsp0_valid;
    logic [N-1:0] rsp0_result;
    logic         rsp1_valid;
    logic [N-1:0] rsp1_result;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer for a shared ALU: accept in IDLE, drive the ALU
// in EXEC, capture the result into the winner's response register, own NZCV.
module alu_arbiter #(
    parameter int N = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_arbiter_if.slave  bus,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [3:0]    alu_ctrl,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_zero,
    input  logic          alu_negative,
    input  logic          alu_carry,
    input  logic          alu_overflow,
    output logic [3:0]    nzcv
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         last;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [3:0]   op_ctrl;
    logic         op_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Under contention the port that did not win last time is granted.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctrl   = 4'b0000;
        case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant0 = last;
                    grant1 = !last;
                end else begin
                    grant0 = bus.req0_valid;
                    grant1 = bus.req1_valid;
                end
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                alu_a      = op_a;
                alu_b      = op_b;
                alu_ctrl   = op_ctrl;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign accept         = grant0 || grant1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last            <= 1'b1;
            op_a            <= '0;
            op_b            <= '0;
            op_ctrl         <= 4'b0000;
            op_id           <= 1'b0;
            nzcv            <= 4'b0000;
            bus.rsp0_valid  <= 1'b0;
            bus.rsp1_valid  <= 1'b0;
            bus.rsp0_result <= '0;
            bus.rsp1_result <= '0;
        end else begin
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            if (accept) begin
                op_a    <= grant1 ? bus.req1_a  : bus.req0_a;
                op_b    <= grant1 ? bus.req1_b  : bus.req0_b;
                op_ctrl <= grant1 ? bus.req1_op : bus.req0_op;
                op_id   <= grant1;
                last    <= grant1;
            end
            // Flags land in the same edge as the response, ahead of any later EXEC.
            if (state == EXEC) begin
                if (op_id) begin
                    bus.rsp1_valid  <= 1'b1;
                    bus.rsp1_result <= alu_result;
                end else begin
                    bus.rsp0_valid  <= 1'b1;
                    bus.rsp0_result <= alu_result;
                end
                if (op_ctrl[3]) begin
                    nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural ALU and a
// transaction-level model of arbitration, latency and NZCV ownership.
module tb_alu_arbiter;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         alu_negative;
    logic         alu_carry;
    logic         alu_overflow;
    logic [3:0]   nzcv;
    logic         force_flags;
    logic [3:0]   forced_flags;
    int           cyc = 0;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .nzcv         (nzcv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic [3:0] op);
        case (op[2:0])
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [3:0] op);
        logic [N:0]   wide;
        logic [N-1:0] r;
        logic         c;
        logic         v;
        r = ref_result(a, b, op);
        c = 1'b0;
        v = 1'b0;
        if (op[2:0] == 3'b010) begin
            wide = {1'b0, a} + {1'b0, b};
            c    = wide[N];
            v    = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        end else if (op[2:0] == 3'b110) begin
            wide = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
            c    = wide[N];
            v    = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
        end
        return {r[N-1], r == '0, c, v};
    endfunction

    // Behavioural stand-in for the shared ALU; flags may be pinned by the bench.
    assign alu_result = ref_result(alu_a, alu_b, alu_ctrl);
    assign {alu_negative, alu_zero, alu_carry, alu_overflow} =
        force_flags ? forced_flags : ref_flags(alu_a, alu_b, alu_ctrl);

    typedef struct {
        logic         port;
        logic [N-1:0] result;
        logic [3:0]   flags;
        int           due;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_err = 0;
    logic         model_last;
    logic [3:0]   model_nzcv;
    int           accept_cyc;
    logic [N-1:0] exec_a;
    logic [N-1:0] exec_b;
    logic [3:0]   exec_op;

    task automatic compare(input string name, input logic [N-1:0] act_v, input logic [N-1:0] req_v);
        n_cmp++;
        if (act_v !== req_v) begin
            n_err++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act_v, req_v, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        sb.delete();
        model_last = 1'b1;
        model_nzcv = 4'b0000;
        accept_cyc = -10;
    endtask

    // Monitor: pops the scoreboard whenever a response strobe is seen.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (bus.rsp0_valid && bus.rsp1_valid) begin
                fail_now("rsp_both_ports");
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sb.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    mon_e = sb.pop_front();
                    compare("rsp_port", N'(bus.rsp1_valid), N'(mon_e.port));
                    compare("rsp_result", bus.rsp1_valid ? bus.rsp1_result : bus.rsp0_result,
                            mon_e.result);
                    compare("rsp_nzcv", N'(nzcv), N'(mon_e.flags));
                    compare("rsp_cycle", N'(cyc), N'(mon_e.due));
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                fail_now("rsp_missing");
            end
        end
    end

    // Compares ready and ALU drive against the model and records accepts.
    task automatic check_output(output logic acc0, output logic acc1);
        logic         busy;
        logic         v0;
        logic         v1;
        logic         w;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic [3:0]   fl;
        busy = (cyc == accept_cyc + 1);
        v0   = bus.req0_valid;
        v1   = bus.req1_valid;
        acc0 = !busy && v0 && (!v1 || model_last);
        acc1 = !busy && v1 && (!v0 || !model_last);
        compare("req0_ready", N'(bus.req0_ready), N'(acc0));
        compare("req1_ready", N'(bus.req1_ready), N'(acc1));
        compare("alu_a", alu_a, busy ? exec_a : '0);
        compare("alu_b", alu_b, busy ? exec_b : '0);
        compare("alu_ctrl", N'(alu_ctrl), busy ? N'(exec_op) : '0);
        if (acc0 || acc1) begin
            w  = acc1;
            a  = w ? bus.req1_a  : bus.req0_a;
            b  = w ? bus.req1_b  : bus.req0_b;
            op = w ? bus.req1_op : bus.req0_op;
            fl = force_flags ? forced_flags : ref_flags(a, b, op);
            if (op[3]) model_nzcv = fl;
            sb.push_back('{w, ref_result(a, b, op), model_nzcv, cyc + 2});
            model_last = w;
            accept_cyc = cyc;
            exec_a     = a;
            exec_b     = b;
            exec_op    = op;
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                                  input logic [3:0] op0, input logic v1, input logic [N-1:0] a1,
                                  input logic [N-1:0] b1, input logic [3:0] op1,
                                  output logic acc0, output logic acc1);
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req0_op    = op0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.req1_op    = op1;
        #1;
        check_output(acc0, acc1);
    endtask

    task automatic idle_cycles(input int n);
        logic x0;
        logic x1;
        for (int i = 0; i < n; i++) apply_stimulus(0, '0, '0, 4'h0, 0, '0, '0, 4'h0, x0, x1);
    endtask

    task automatic run_op(input logic port, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [3:0] op);
        logic x0;
        logic x1;
        int   k;
        k = 0;
        do begin
            apply_stimulus(!port, a, b, op, port, a, b, op, x0, x1);
            k++;
        end while (!(x0 || x1) && k < 10);
        if (!(x0 || x1)) fail_now("run_op_timeout");
        idle_cycles(2);
    endtask

    task automatic check_reset_state();
        compare("reset_nzcv", N'(nzcv), '0);
        compare("reset_rsp0_result", bus.rsp0_result, '0);
        compare("reset_rsp1_result", bus.rsp1_result, '0);
        compare("reset_rsp_valid", N'({bus.rsp0_valid, bus.rsp1_valid}), '0);
        compare("reset_alu_a", alu_a, '0);
        compare("reset_alu_ctrl", N'(alu_ctrl), '0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic         a0;
        logic         a1;
        logic         pv[2];
        logic [N-1:0] pa[2];
        logic [N-1:0] pb[2];
        logic [3:0]   pop[2];
        logic         prev_w;
        int           grants;
        int           k;

        reset_n        = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_op    = 4'h0;
        bus.req1_valid = 1'b0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_op    = 4'h0;
        force_flags    = 1'b0;
        forced_flags   = 4'b0000;
        exec_a         = '0;
        exec_b         = '0;
        exec_op        = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_state();

        // Contention straight after reset: R0 first, then R1.
        pv[0] = 1'b1;
        pv[1] = 1'b1;
        k     = 0;
        while ((pv[0] || pv[1]) && k < 10) begin
            apply_stimulus(pv[0], 64'd10, 64'd5, 4'b0110, pv[1], 64'd20, 64'd30, 4'b0010, a0, a1);
            if (k == 0) compare("first_grant_r0", N'(bus.req0_ready), N'(1'b1));
            if (a0) pv[0] = 1'b0;
            if (a1) pv[1] = 1'b0;
            k++;
        end
        if (pv[0] || pv[1]) fail_now("contention_timeout");
        idle_cycles(3);

        // Single ADDS 3 + 4 on R0.
        run_op(1'b0, 64'd3, 64'd4, 4'b1010);
        compare("adds_nzcv", N'(nzcv), '0);

        // Both requesters hold valid continuously: grants must alternate.
        for (int i = 0; i < 2; i++) begin
            pa[i]  = {$urandom, $urandom};
            pb[i]  = {$urandom, $urandom};
            pop[i] = 4'($urandom_range(0, 15));
        end
        grants = 0;
        prev_w = 1'b0;
        k      = 0;
        while (grants < 8 && k < 40) begin
            apply_stimulus(1, pa[0], pb[0], pop[0], 1, pa[1], pb[1], pop[1], a0, a1);
            compare("single_grant", N'(bus.req0_ready && bus.req1_ready), '0);
            if (bus.req0_ready || bus.req1_ready) begin
                if (grants > 0) compare("fair_alternate", N'(bus.req1_ready), N'(!prev_w));
                prev_w = bus.req1_ready;
                grants++;
            end
            if (a0) begin pa[0] = {$urandom, $urandom}; pop[0] = 4'($urandom_range(0, 15)); end
            if (a1) begin pa[1] = {$urandom, $urandom}; pop[1] = 4'($urandom_range(0, 15)); end
            k++;
        end
        if (grants < 8) fail_now("fairness_timeout");
        idle_cycles(3);

        // Flag isolation: SUBS sets flags, AND must not touch them.
        force_flags  = 1'b1;
        forced_flags = 4'b0110;
        run_op(1'b1, 64'd9, 64'd9, 4'b1110);
        compare("subs_nzcv", N'(nzcv), N'(4'b0110));
        forced_flags = 4'b1111;
        run_op(1'b0, 64'hF0, 64'h3C, 4'b0000);
        compare("and_keeps_nzcv", N'(nzcv), N'(4'b0110));
        force_flags = 1'b0;

        // R1 raises valid only while busy, then withdraws.
        apply_stimulus(1, 64'd100, 64'd1, 4'b0110, 0, '0, '0, 4'h0, a0, a1);
        compare("withdraw_setup_accept", N'(a0), N'(1'b1));
        apply_stimulus(0, '0, '0, 4'h0, 1, 64'd7, 64'd8, 4'b0010, a0, a1);
        compare("withdraw_no_grant", N'(bus.req1_ready), '0);
        idle_cycles(4);

        // Randomized traffic with occasional withdrawal.
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i]  = 1'b1;
                    pa[i]  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : {$urandom, $urandom};
                    pb[i]  = ($urandom_range(0, 3) == 0) ? pa[i] : {$urandom, $urandom};
                    pop[i] = 4'($urandom_range(0, 15));
                end else if (pv[i] && $urandom_range(0, 9) == 0) begin
                    pv[i] = 1'b0;
                end
            end
            apply_stimulus(pv[0], pa[0], pb[0], pop[0], pv[1], pa[1], pb[1], pop[1], a0, a1);
            if (a0) pv[0] = 1'b0;
            if (a1) pv[1] = 1'b0;
        end
        idle_cycles(4);
        compare("drain_scoreboard", N'(sb.size()), '0);

        // Leave flags non-zero, then reset in the middle of a flag-setting op.
        force_flags  = 1'b1;
        forced_flags = 4'b1001;
        run_op(1'b0, 64'd1, 64'd2, 4'b1010);
        forced_flags = 4'b1111;
        apply_stimulus(1, 64'd5, 64'd6, 4'b1010, 0, '0, '0, 4'h0, a0, a1);
        compare("reset_op_accept", N'(a0), N'(1'b1));
        @(negedge clk);
        reset_n        = 1'b0;
        bus.req0_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_state();
        force_flags = 1'b0;
        idle_cycles(2);
        compare("post_reset_nzcv", N'(nzcv), '0);
        apply_stimulus(1, 64'd1, 64'd1, 4'b0001, 1, 64'd2, 64'd2, 4'b0001, a0, a1);
        compare("post_reset_r0_wins", N'(bus.req0_ready), N'(1'b1));
        idle_cycles(4);
        compare("final_scoreboard", N'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
